arb_rr_param: RTL and testbench
===============================

Name: arb_rr_param

Overview:
Parametrised round-robin arbiter, successor to the 2-requester arbiter on arb_if. It arbitrates N requesters onto one shared resource and produces a registered one-hot grant. The current owner keeps the grant while it holds its request, with an optional fairness limit on hold time. It sits behind the arbiter interface, with request/grant widened to N bits, and drives the DUT side of that interface.

Parameters:
N, 4, number of requesters (2..32)
HOLD_MAX, 8, max consecutive grant cycles for one owner while others request (>=1; used only with ARB_HOLD_LIMIT_EN)
IDX_W, $clog2(N), width of grant_idx (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
request  input  N  per-requester request, level, bit i = requester i
grant  output  N  registered one-hot grant, all-zero when idle
grant_valid  output  1  OR of grant, registered
grant_idx  output  IDX_W  index of granted requester, 0 when idle
hold_cnt  output  $clog2(HOLD_MAX+1)  cycles current owner has held grant, saturating

Behaviour:
- Reset (reset=0, async): grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, last-grant pointer ptr=N-1, so the first arbitration favours requester 0.
- The block keeps state IDLE (grant=0) or OWNED (grant one-hot). All outputs are registered.
- Latency: the grant reflects the request sampled at the previous rising edge, 1 cycle.
- Winner search: first set bit of request scanning ptr+1, ptr+2, ... mod N. Wrap from N-1 to 0 is required.
- IDLE: request==0 -> stay IDLE. Otherwise grant the winner, set ptr=winner, hold_cnt=1, go to OWNED.
- OWNED, owner request still 1:
  - No other request -> keep grant; hold_cnt increments, saturating at HOLD_MAX.
  - Other request pending and hold limit not reached -> keep grant; hold_cnt++.
  - Other request pending and hold limit reached (hold_cnt==HOLD_MAX, feature enabled) -> grant the winner among the others (owner excluded); hold_cnt=1; ptr=new winner.
- OWNED, owner request 0:
  - Other requests pending -> grant the winner in the same edge (no idle bubble); hold_cnt=1.
  - No other requests -> go to IDLE: grant=0, hold_cnt=0. ptr keeps the last owner.
- Simultaneous requests: exactly one grant bit is ever set. The owner never sees grant drop and reassert in the same cycle.
- Reset mid-grant: grant clears asynchronously. After reset release, arbitration restarts from ptr=N-1.
- Requests for bits >= N do not exist. The grant_idx encoding matches the grant one-hot position.

Optional Feature:
Macro ARB_HOLD_LIMIT_EN.
- Defined: the HOLD_MAX fairness limit applies as above.
- Undefined: the owner keeps the grant for as long as its request stays high, regardless of other requests. hold_cnt still counts and saturates at HOLD_MAX but has no effect on arbitration.

Test Plan:
- Reset then request=4'b0000 for 5 cycles -> grant=0, grant_valid=0, grant_idx=0 throughout.
- Reset, request=4'b1111 for 1 cycle, then 4'b0000 -> grant=4'b0001 one cycle after the request edge, then IDLE. Next request=4'b1111 -> grant=4'b0010 (rotation from ptr=0).
- Owner handoff: request=4'b0011 held, owner 0 drops request at cycle k -> grant=4'b0010 at edge k+1, no zero cycle between grants.
- Wrap: ptr=3 (last grant 4'b1000), request=4'b1001 -> grant=4'b0001.
- ARB_HOLD_LIMIT_EN, HOLD_MAX=8: request=4'b0101 held continuously -> grant 4'b0001 for exactly 8 cycles, then 4'b0100 for 8, alternating. Without the macro -> 4'b0001 held indefinitely.
- Assert reset=0 mid-grant -> grant=0 immediately (before the next clk edge). Release with request=4'b0100 -> grant=4'b0100 one cycle later.

Source files
------------

// File: rtl/arb_rr_param.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_param
// Description : N-way round-robin arbiter with registered one-hot grant and
//               owner hold; optional hold-time fairness limit via the
//               ARB_HOLD_LIMIT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_param #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N-1:0]                  request,
    output logic [N-1:0]                  grant,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic [$clog2(HOLD_MAX+1)-1:0] hold_cnt
);

    localparam int                 c_hc_w     = $clog2(HOLD_MAX + 1);
    localparam logic [0:0]         c_st_idle  = 1'b0;
    localparam logic [0:0]         c_st_owned = 1'b1;
    localparam logic [N-1:0]       c_one      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [c_hc_w-1:0]  c_hold_max = c_hc_w'(HOLD_MAX);
    localparam logic [IDX_W-1:0]   c_ptr_rst  = IDX_W'(N - 1);

    logic [0:0]        r_state, w_state;
    logic [N-1:0]      r_grant, w_grant;
    logic [IDX_W-1:0]  r_idx,   w_idx;
    logic [IDX_W-1:0]  r_ptr,   w_ptr;
    logic [c_hc_w-1:0] r_hold,  w_hold;

    logic [N-1:0]      w_others;
    logic              w_others_any;
    logic              w_owner_req;
    logic              w_limit;
    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_j;

    // The owner is masked out, so in OWNED the search only sees challengers;
    // in IDLE r_grant is zero and the mask is a no-op.
    assign w_others     = request & ~r_grant;
    assign w_others_any = |w_others;
    assign w_owner_req  = |(request & r_grant);

`ifdef ARB_HOLD_LIMIT_EN
    assign w_limit = (r_hold == c_hold_max);
`else
    assign w_limit = 1'b0;
`endif

    // Rotating priority: first set bit at ptr+1, ptr+2, ... wrapping mod N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = IDX_W'((int'(r_ptr) + k) % N);
            if (!w_found && w_others[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_idx   = r_idx;
        w_ptr   = r_ptr;
        w_hold  = r_hold;
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_state = c_st_owned;
                    w_grant = c_one << w_win;
                    w_idx   = w_win;
                    w_ptr   = w_win;
                    w_hold  = c_hc_w'(1);
                end
            end
            c_st_owned: begin
                if (w_owner_req && !(w_others_any && w_limit)) begin
                    w_hold = (r_hold == c_hold_max) ? r_hold : r_hold + 1'b1;
                end else if (w_found) begin
                    // Direct handoff in the same edge, no idle bubble.
                    w_grant = c_one << w_win;
                    w_idx   = w_win;
                    w_ptr   = w_win;
                    w_hold  = c_hc_w'(1);
                end else begin
                    w_state = c_st_idle;
                    w_grant = '0;
                    w_idx   = '0;
                    w_hold  = '0;
                end
            end
            default: begin
                w_state = c_st_idle;
                w_grant = '0;
                w_idx   = '0;
                w_hold  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= c_ptr_rst;
            r_hold  <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_idx   <= w_idx;
            r_ptr   <= w_ptr;
            r_hold  <= w_hold;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_state;
    assign grant_idx   = r_idx;
    assign hold_cnt    = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_rr_param
// Description : Scoreboard bench for arb_rr_param (N=4, HOLD_MAX=8) with an
//               owner/pointer reference model and randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_rr_param;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
        logic [3:0] h;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] hold_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference state: owner index (-1 when idle), last-grant pointer, hold.
    int m_owner;
    int m_ptr;
    int m_hold;

    arb_rr_param #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .hold_cnt   (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    function automatic int pick(input int rq, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (((rq >> i) & 1) == 1 && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_hold  = 0;
    endtask

    task automatic model_step(input int rq);
        int  w;
        bit  limit;
        int  others;
`ifdef ARB_HOLD_LIMIT_EN
        limit = (m_hold == HOLD_MAX);
`else
        limit = 1'b0;
`endif
        if (m_owner < 0) begin
            w = pick(rq, -1);
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_hold = 1;
            end
        end else begin
            others = rq & ~(1 << m_owner);
            if (((rq >> m_owner) & 1) == 1 && !(others != 0 && limit)) begin
                if (m_hold < HOLD_MAX) m_hold++;
            end else if (others != 0) begin
                w = pick(others, m_owner);
                m_owner = w; m_ptr = w; m_hold = 1;
            end else begin
                m_owner = -1; m_hold = 0;
            end
        end
    endtask

    task automatic drive(input logic [3:0] rq);
        exp_t e;
        @(negedge clk);
        request = rq;
        model_step(int'(rq));
        e.g   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.v   = (m_owner >= 0);
        e.idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.h   = 4'(m_hold);
        sb.push_back(e);
    endtask

    // Monitor: compares every registered output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant",       32'(grant),       32'(e.g));
                chk("grant_valid", 32'(grant_valid), 32'(e.v));
                chk("grant_idx",   32'(grant_idx),   32'(e.idx));
                chk("hold_cnt",    32'(hold_cnt),    32'(e.h));
                chk("onehot0",     32'($onehot0(grant)), 32'd1);
            end
        end
    end

    initial begin
        logic [3:0] cur;
        reset   = 1'b0;
        request = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant),       32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_idx",   32'(grant_idx),   32'd0);
        chk("rst_hold",  32'(hold_cnt),    32'd0);
        reset = 1'b1;

        // Idle, then single-cycle all-request and rotation from ptr=0.
        repeat (5) drive(4'b0000);
        drive(4'b1111);
        drive(4'b0000);
        drive(4'b1111);
        drive(4'b0000);

        // Owner handoff without bubble.
        repeat (3) drive(4'b0011);
        repeat (3) drive(4'b0010);
        drive(4'b0000);

        // Wrap from ptr=3 to requester 0.
        drive(4'b1000);
        drive(4'b0000);
        drive(4'b1001);
        drive(4'b0000);

        // Long hold with a challenger: exercises saturation or the fairness limit.
        repeat (20) drive(4'b0101);
        drive(4'b0000);

        // Asynchronous reset in the middle of a grant.
        repeat (2) drive(4'b0010);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_grant", 32'(grant),       32'd0);
        chk("async_rst_valid", 32'(grant_valid), 32'd0);
        chk("async_rst_hold",  32'(hold_cnt),    32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(4'b0100);
        drive(4'b0000);

        // Randomized requests, held for random stretches.
        cur = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
            drive(cur);
        end
        drive(4'b0000);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
